wb_sram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single 16-bit SRAM slave port between the CPU data path (master 0) and a second bus master such as a framebuffer/DMA fetch engine (master 1). Sits between the masters and `wb_sram16`, on the slave side of the interconnect's SRAM window. Grants whole bus cycles round-robin and guards the slave with an ack watchdog that terminates hung cycles with `err`.

---
 rtl/wb_sram_arbiter_if.sv | 34 +++
 rtl/wb_sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_sram_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_arbiter_if.sv
// Wishbone bus bundle shared by the arbiter's two upstream masters and its
// downstream SRAM slave port.
//   adr   32  address              (master -> slave)
//   wdat  32  write data           (master -> slave)
//   sel    4  byte selects         (master -> slave)
//   we     1  write enable         (master -> slave)
//   cyc    1  bus cycle / request  (master -> slave)
//   stb    1  transfer strobe      (master -> slave)
//   rdat  32  read data            (slave -> master)
//   ack    1  transfer acknowledge (slave -> master)
//   err    1  abort / error        (slave -> master)
// The SRAM slave has no error output, so the master modport leaves err out.
// The arbiter's own err is delivered on the slave modport toward each master.
interface wb_sram_arbiter_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output adr, wdat, sel, we, cyc, stb,
    input  rdat, ack
  );

  modport slave (
    input  adr, wdat, sel, we, cyc, stb,
    output rdat, ack, err
  );
endinterface

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone arbiter in front of the 16-bit SRAM slave.
// Whole bus cycles are granted round-robin and never preempted, so
// multi-beat and read-modify-write sequences stay atomic. An ack watchdog
// terminates strobes that the slave leaves unanswered for TIMEOUT cycles.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   m0, m1   master-facing ports (m0 = CPU data path, m1 = DMA/fetch engine)
//   s        slave-facing port toward wb_sram16
//   gnt_o    one-hot grant, bit0 = m0, bit1 = m1, 2'b00 when idle
// Parameters:
//   TIMEOUT  un-acked strobe cycles before abort, 0 disables the watchdog
//   CNT_W    watchdog counter width, TIMEOUT < 2**CNT_W
module wb_sram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  wb_sram_arbiter_if.slave       m0,
  wb_sram_arbiter_if.slave       m1,
  wb_sram_arbiter_if.master      s,
  output logic [1:0]             gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic             WDOG_ON     = (TIMEOUT != 0);

  state_t           state;
  logic             last;      // last-served master: 0 = m0, 1 = m1
  logic [1:0]       gnt_reg;
  logic [CNT_W-1:0] cnt;
  logic             stb_sel;
  logic             abort;

  // Arbitration FSM. gnt_reg is registered alongside state so the grant
  // vector is a clean flop output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      last    <= 1'b1;         // m0 wins the first contention
      gnt_reg <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // On contention serve whichever master was not served last.
          if (m0.cyc && (!m1.cyc || last)) begin
            state   <= GNT0;
            last    <= 1'b0;
            gnt_reg <= 2'b01;
          end else if (m1.cyc) begin
            state   <= GNT1;
            last    <= 1'b1;
            gnt_reg <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0.cyc) begin
            if (m1.cyc) begin
              // Direct handover, no idle bubble.
              state   <= GNT1;
              last    <= 1'b1;
              gnt_reg <= 2'b10;
            end else begin
              state   <= IDLE;
              gnt_reg <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!m1.cyc) begin
            if (m0.cyc) begin
              state   <= GNT0;
              last    <= 1'b0;
              gnt_reg <= 2'b01;
            end else begin
              state   <= IDLE;
              gnt_reg <= 2'b00;
            end
          end
        end
        default: begin
          state   <= IDLE;
          gnt_reg <= 2'b00;
        end
      endcase
    end
  end

  // Slave-side mux. When idle the address/data/sel path follows m0 so the
  // slave sees stable values, but no cycle, strobe or write is issued.
  always_comb begin
    s.adr   = m0.adr;
    s.wdat  = m0.wdat;
    s.sel   = m0.sel;
    s.we    = 1'b0;
    s.cyc   = 1'b0;
    stb_sel = 1'b0;
    case (state)
      GNT0: begin
        s.we    = m0.we;
        s.cyc   = m0.cyc;
        stb_sel = m0.stb;
      end
      GNT1: begin
        s.adr   = m1.adr;
        s.wdat  = m1.wdat;
        s.sel   = m1.sel;
        s.we    = m1.we;
        s.cyc   = m1.cyc;
        stb_sel = m1.stb;
      end
      default: ;
    endcase
  end

  // A same-cycle ack always beats the abort.
  assign abort = (cnt == TIMEOUT_CNT) && WDOG_ON && !s.ack;
  assign s.stb = stb_sel & ~abort;

  // Watchdog: counts consecutive un-acked strobe cycles, saturating at
  // TIMEOUT. Clearing on abort restarts the window if stb stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!s.stb || s.ack || abort) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT_CNT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;
  assign m0.ack  = s.ack & gnt_reg[0];
  assign m1.ack  = s.ack & gnt_reg[1];
  assign m0.err  = abort & gnt_reg[0];
  assign m1.err  = abort & gnt_reg[1];
  assign gnt_o   = gnt_reg;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
module tb_wb_sram_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] gnt_a;
  logic [1:0] gnt_z;

  int n_asserts = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  // DUT with an 8-cycle watchdog.
  wb_sram_arbiter_if m0_a();
  wb_sram_arbiter_if m1_a();
  wb_sram_arbiter_if s_a();

  wb_sram_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_a),
    .m1      (m1_a),
    .s       (s_a),
    .gnt_o   (gnt_a)
  );

  // DUT with the watchdog disabled.
  wb_sram_arbiter_if m0_z();
  wb_sram_arbiter_if m1_z();
  wb_sram_arbiter_if s_z();

  wb_sram_arbiter #(.TIMEOUT(0), .CNT_W(4)) dut_nowd (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_z),
    .m1      (m1_z),
    .s       (s_z),
    .gnt_o   (gnt_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_a.adr = 32'h1234_5678; m0_a.wdat = 32'h0BAD_F00D; m0_a.sel = 4'hA;
    m0_a.we = 1'b1; m0_a.cyc = 1'b0; m0_a.stb = 1'b0;
    m1_a.adr = 32'h8765_4321; m1_a.wdat = 32'h5555_AAAA; m1_a.sel = 4'h5;
    m1_a.we = 1'b0; m1_a.cyc = 1'b0; m1_a.stb = 1'b0;
    s_a.rdat = 32'h0; s_a.ack = 1'b0; s_a.err = 1'b0;
    m0_z.adr = 32'h0; m0_z.wdat = 32'h0; m0_z.sel = 4'h0;
    m0_z.we = 1'b0; m0_z.cyc = 1'b0; m0_z.stb = 1'b0;
    m1_z.adr = 32'h0; m1_z.wdat = 32'h0; m1_z.sel = 4'h0;
    m1_z.we = 1'b0; m1_z.cyc = 1'b0; m1_z.stb = 1'b0;
    s_z.rdat = 32'h0; s_z.ack = 1'b0; s_z.err = 1'b0;

    // ---- reset state ----
    step(); step();
    check("rst_gnt", 32'(gnt_a), 32'h0);
    check("rst_cyc", 32'(s_a.cyc), 32'h0);
    check("rst_stb", 32'(s_a.stb), 32'h0);
    check("rst_we", 32'(s_a.we), 32'h0);
    check("rst_ack0", 32'(m0_a.ack), 32'h0);
    check("rst_err0", 32'(m0_a.err), 32'h0);
    check("rst_adr", s_a.adr, 32'h1234_5678);
    check("rst_dat", s_a.wdat, 32'h0BAD_F00D);
    check("rst_sel", 32'(s_a.sel), 32'hA);
    check("rst_gnt_z", 32'(gnt_z), 32'h0);
    $display("txn reset checked");
    reset_n = 1'b1;

    // Watchdog-disabled DUT: m0 strobes forever with no ack.
    m0_z.cyc = 1'b1; m0_z.stb = 1'b1;

    // ---- single master read ----
    step();
    m0_a.adr = 32'h4000_0010; m0_a.we = 1'b0; m0_a.sel = 4'hF;
    m0_a.cyc = 1'b1; m0_a.stb = 1'b1;
    exp_q.push_back(32'hCAFE_1234);
    step();
    check("rd_gnt", 32'(gnt_a), 32'h1);
    check("rd_s_stb", 32'(s_a.stb), 32'h1);
    check("rd_s_adr", s_a.adr, 32'h4000_0010);
    check("rd_s_we", 32'(s_a.we), 32'h0);
    step();
    check("rd_noack", 32'(m0_a.ack), 32'h0);
    step();
    s_a.ack = 1'b1; s_a.rdat = 32'hCAFE_1234;
    #1;
    check("rd_ack0", 32'(m0_a.ack), 32'h1);
    check("rd_ack1", 32'(m1_a.ack), 32'h0);
    exp_v = exp_q.pop_front();
    check("rd_data", m0_a.rdat, exp_v);
    $display("txn m0 read adr=%h data=%h", m0_a.adr, m0_a.rdat);
    step();
    m0_a.cyc = 1'b0; m0_a.stb = 1'b0; s_a.ack = 1'b0;
    step();
    check("rd_idle", 32'(gnt_a), 32'h0);

    // ---- contention after reset ----
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m0_a.cyc = 1'b1; m0_a.stb = 1'b1;
    m1_a.cyc = 1'b1; m1_a.stb = 1'b1;
    step();
    check("cont_first_m0", 32'(gnt_a), 32'h1);
    m0_a.cyc = 1'b0; m0_a.stb = 1'b0;
    step();
    check("cont_handover", 32'(gnt_a), 32'h2);
    check("cont_ho_cyc", 32'(s_a.cyc), 32'h1);
    $display("txn contention handover m0->m1");
    m1_a.cyc = 1'b0; m1_a.stb = 1'b0;
    step();
    check("cont_idle", 32'(gnt_a), 32'h0);
    m0_a.cyc = 1'b1; m0_a.stb = 1'b1;
    m1_a.cyc = 1'b1; m1_a.stb = 1'b1;
    step();
    check("cont_alt_m0", 32'(gnt_a), 32'h1);
    $display("txn contention repeat -> m0");
    m0_a.cyc = 1'b0; m0_a.stb = 1'b0;
    m1_a.cyc = 1'b0; m1_a.stb = 1'b0;
    step();
    step();
    check("cont_idle2", 32'(gnt_a), 32'h0);

    // ---- atomic hold: m1 four beats, m0 requesting throughout ----
    m0_a.cyc = 1'b1; m0_a.stb = 1'b1;
    m1_a.cyc = 1'b1; m1_a.stb = 1'b1;
    step();
    check("atom_gnt", 32'(gnt_a), 32'h2);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hD000_0000 + 32'(i));
      s_a.ack = 1'b1; s_a.rdat = 32'hD000_0000 + 32'(i);
      #1;
      check("atom_gnt_beat", 32'(gnt_a), 32'h2);
      check("atom_ack1", 32'(m1_a.ack), 32'h1);
      check("atom_ack0", 32'(m0_a.ack), 32'h0);
      exp_v = exp_q.pop_front();
      check("atom_data", m1_a.rdat, exp_v);
      $display("txn m1 beat %0d data=%h", i, m1_a.rdat);
      step();
    end
    m1_a.cyc = 1'b0; m1_a.stb = 1'b0; s_a.ack = 1'b0;
    step();
    check("atom_to_m0", 32'(gnt_a), 32'h1);
    m0_a.cyc = 1'b0; m0_a.stb = 1'b0;
    step();

    // ---- watchdog: slave never acks ----
    m0_a.cyc = 1'b1; m0_a.stb = 1'b1;
    step();
    check("wd_stb0", 32'(s_a.stb), 32'h1);
    check("wd_err0", 32'(m0_a.err), 32'h0);
    for (int k = 1; k <= 17; k++) begin
      logic e;
      step();
      e = (k == 8) || (k == 17);
      check($sformatf("wd_err_k%0d", k), 32'(m0_a.err), 32'(e));
      check($sformatf("wd_stb_k%0d", k), 32'(s_a.stb), 32'(!e));
      check("wd_err1", 32'(m1_a.err), 32'h0);
      check("nowd_err", 32'(m0_z.err), 32'h0);
      check("nowd_stb", 32'(s_z.stb), 32'h1);
    end
    $display("txn m0 watchdog aborts observed");
    m0_a.cyc = 1'b0; m0_a.stb = 1'b0;
    step();

    // ---- ack/abort race ----
    m0_a.cyc = 1'b1; m0_a.stb = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) step();
    s_a.ack = 1'b1; s_a.rdat = 32'h0000_BEEF;
    #1;
    check("race_ack", 32'(m0_a.ack), 32'h1);
    check("race_noerr", 32'(m0_a.err), 32'h0);
    check("race_stb", 32'(s_a.stb), 32'h1);
    $display("txn m0 late ack at timeout");
    step();
    m0_a.cyc = 1'b0; m0_a.stb = 1'b0; s_a.ack = 1'b0;
    step();

    // ---- reset mid-transfer during an m1 write ----
    m1_a.adr = 32'h4000_0100; m1_a.we = 1'b1;
    m1_a.cyc = 1'b1; m1_a.stb = 1'b1;
    step();
    check("mrst_gnt", 32'(gnt_a), 32'h2);
    check("mrst_we", 32'(s_a.we), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_cyc", 32'(s_a.cyc), 32'h0);
    check("mrst_stb", 32'(s_a.stb), 32'h0);
    check("mrst_we0", 32'(s_a.we), 32'h0);
    check("mrst_gnt0", 32'(gnt_a), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("mrst_regnt", 32'(gnt_a), 32'h2);
    $display("txn m1 write interrupted by reset and re-granted");
    m1_a.cyc = 1'b0; m1_a.stb = 1'b0; m1_a.we = 1'b0;
    step();

    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
